// File: rtl/uart_rx_pkg.sv
// Shared UART definitions: state encodings (also used to decode UART_tx debug
// outputs), divisor width and limits, and the divisor clamp helper.
package uart_rx_pkg;

    localparam int CPD_WIDTH = 10;
    localparam int DATA_BITS = 8;
    localparam logic [CPD_WIDTH-1:0] CPD_MIN = 10'd4;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_DONE  = 3'd4
    } rx_state_e;

    // Divisors below CPD_MIN leave too little room for a mid-bit sample.
    function automatic logic [CPD_WIDTH-1:0] clamp_cpd(input logic [CPD_WIDTH-1:0] cpd);
        return (cpd < CPD_MIN) ? CPD_MIN : cpd;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Multi-flop synchroniser for the asynchronous serial line. Presets to 1 so
// the line reads idle while reset is applied.
module uart_rx_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic resetn,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] ff;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ff <= '1;
        end else begin
            ff <= {ff[STAGES-2:0], d};
        end
    end

    assign q = ff[STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver. Samples each bit at mid-period using a runtime divisor
// latched at start-bit detection; reports good frames and framing errors.
module uart_rx #(
    parameter int SYNC_STAGES = 2,
    parameter int DATA_BITS   = 8
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic [9:0]           cycles_per_databit,
    input  logic                 rx_line,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 rx_frame_err,
    output logic                 rx_busy,
    output logic [2:0]           curr,
    output logic [2:0]           next
);
    import uart_rx_pkg::*;

    rx_state_e              state_q;
    rx_state_e              state_d;
    logic [CPD_WIDTH-1:0]   timer_q;
    logic [CPD_WIDTH-1:0]   cpd_q;
    logic [CPD_WIDTH-1:0]   limit;
    logic [2:0]             bit_cnt_q;
    logic [DATA_BITS-1:0]   shift_q;
    logic                   sample;
    logic                   rs;

    uart_rx_sync #(.STAGES(SYNC_STAGES)) u_sync (
        .clk    (clk),
        .resetn (resetn),
        .d      (rx_line),
        .q      (rs)
    );

    // START waits half a bit to land mid start bit; later bits wait a full bit.
    always_comb begin
        limit = cpd_q - 1'b1;
        if (state_q == ST_START) begin
            limit = cpd_q >> 1;
        end
    end

    assign sample = (timer_q == limit);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (!rs) state_d = ST_START;
            ST_START: if (sample) state_d = rs ? ST_IDLE : ST_DATA;
            ST_DATA:  if (sample && (bit_cnt_q == 3'(DATA_BITS - 1))) state_d = ST_STOP;
            ST_STOP:  if (sample) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            timer_q      <= '0;
            cpd_q        <= '0;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            rx_data      <= '0;
            rx_valid     <= 1'b0;
            rx_frame_err <= 1'b0;
        end else begin
            timer_q      <= ((state_d != state_q) || sample) ? '0 : timer_q + 1'b1;
            rx_valid     <= 1'b0;
            rx_frame_err <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (!rs) cpd_q <= clamp_cpd(cycles_per_databit);
                end
                ST_START: begin
                    if (sample && !rs) bit_cnt_q <= '0;
                end
                ST_DATA: begin
                    // LSB arrives first, so shift right and insert at the top.
                    if (sample) begin
                        shift_q   <= {rs, shift_q[DATA_BITS-1:1]};
                        bit_cnt_q <= bit_cnt_q + 1'b1;
                    end
                end
                ST_STOP: begin
                    if (sample) begin
                        rx_data      <= shift_q;
                        rx_valid     <= rs;
                        rx_frame_err <= !rs;
                    end
                end
                default: ;
            endcase
        end
    end

    assign rx_busy = (state_q == ST_START) || (state_q == ST_DATA) || (state_q == ST_STOP);
    assign curr    = state_q;
    assign next    = state_d;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: directed and randomized 8N1 frames checked against an
// expected-event queue built from the frame contents.
module tb_uart_rx;

    localparam int SYNC = 2;

    logic       clk;
    logic       resetn;
    logic [9:0] cycles_per_databit;
    logic       rx_line;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_frame_err;
    logic       rx_busy;
    logic [2:0] curr;
    logic [2:0] next;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int last_start_cyc = 0;
    int last_valid_cyc = 0;
    int valid_cycles = 0;
    int err_cycles = 0;
    int n_valid_exp = 0;
    int n_err_exp = 0;
    logic both_seen = 1'b0;

    // Each event: {frame_error, byte}.
    logic [8:0] exp_q[$];
    logic [8:0] got_q[$];

    uart_rx #(.SYNC_STAGES(SYNC), .DATA_BITS(8)) dut (
        .clk                (clk),
        .resetn             (resetn),
        .cycles_per_databit (cycles_per_databit),
        .rx_line            (rx_line),
        .rx_data            (rx_data),
        .rx_valid           (rx_valid),
        .rx_frame_err       (rx_frame_err),
        .rx_busy            (rx_busy),
        .curr               (curr),
        .next               (next)
    );

    // Clock and cycle counter.
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (rx_valid) begin
            got_q.push_back({1'b0, rx_data});
            last_valid_cyc = cyc;
            valid_cycles++;
        end
        if (rx_frame_err) begin
            got_q.push_back({1'b1, rx_data});
            err_cycles++;
        end
        if (rx_valid && rx_frame_err) both_seen = 1'b1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Hold the line at v for n cycles; called at a falling edge.
    task automatic drive(input logic v, input int n);
        if (n > 0) begin
            rx_line = v;
            repeat (n) @(negedge clk);
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input int bit_cycles,
                              input logic stop, input int gap);
        exp_q.push_back({~stop, d});
        if (stop) n_valid_exp++;
        else      n_err_exp++;
        last_start_cyc = cyc;
        drive(1'b0, bit_cycles);
        for (int i = 0; i < 8; i++) drive(d[i], bit_cycles);
        drive(stop, bit_cycles);
        drive(1'b1, gap);
    endtask

    task automatic check_events(input string tag);
        chk({tag, "_count"}, got_q.size(), exp_q.size());
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            chk({tag, "_event"}, 32'(got_q.pop_front()), 32'(exp_q.pop_front()));
        end
        exp_q.delete();
        got_q.delete();
    endtask

    initial begin
        int lat;
        int exp_lat;
        int cpd;
        int eff;
        logic [7:0] d;
        logic       stop;

        // Reset state.
        resetn = 1'b0;
        rx_line = 1'b1;
        cycles_per_databit = 10'd13;
        repeat (3) @(negedge clk);
        chk("reset_rx_data", rx_data, 0);
        chk("reset_rx_valid", rx_valid, 0);
        chk("reset_rx_frame_err", rx_frame_err, 0);
        chk("reset_rx_busy", rx_busy, 0);
        chk("reset_curr", curr, 0);
        chk("reset_next", next, 0);
        resetn = 1'b1;
        repeat (5) @(negedge clk);

        // Clean byte with latency check.
        send_frame(8'h45, 13, 1'b1, 30);
        check_events("clean");
        chk("clean_rx_data", rx_data, 8'h45);
        chk("clean_busy_after", rx_busy, 0);
        lat = last_valid_cyc - last_start_cyc;
        exp_lat = SYNC + 1 + (13 >> 1) + 9 * 13;
        chk("clean_latency_window", 32'((lat >= exp_lat - 1) && (lat <= exp_lat + 1)), 1);

        // Back-to-back frames with no idle gap between them.
        send_frame(8'h45, 13, 1'b1, 0);
        send_frame(8'hA3, 13, 1'b1, 30);
        check_events("b2b");

        // Short glitch: start detected, rejected at mid start bit.
        rx_line = 1'b0;
        repeat (3) @(negedge clk);
        chk("glitch_start_entered", curr, 1);
        rx_line = 1'b1;
        repeat (30) @(negedge clk);
        chk("glitch_curr_idle", curr, 0);
        chk("glitch_busy", rx_busy, 0);
        check_events("glitch");

        // Framing error: stop bit low.
        send_frame(8'hFF, 13, 1'b0, 40);
        check_events("frame_err");
        chk("frame_err_rx_data", rx_data, 8'hFF);

        // Divisor below minimum behaves as 4 cycles per bit.
        cycles_per_databit = 10'd2;
        send_frame(8'h96, 4, 1'b1, 12);
        send_frame(8'h3C, 4, 1'b1, 12);
        check_events("cpd_min");

        // Divisor change mid-frame is ignored until the next frame.
        cycles_per_databit = 10'd13;
        fork
            send_frame(8'hC7, 13, 1'b1, 30);
            begin
                repeat (40) @(negedge clk);
                cycles_per_databit = 10'd20;
            end
        join
        check_events("cpd_hold");

        // Randomized frames with random divisor and occasional bad stop bit.
        for (int i = 0; i < 12; i++) begin
            cpd = $urandom_range(0, 24);
            eff = (cpd < 4) ? 4 : cpd;
            d = 8'($urandom);
            stop = ($urandom_range(0, 3) != 0);
            cycles_per_databit = 10'(cpd);
            send_frame(d, eff, stop, 2 * eff + 4);
        end
        check_events("random");

        // Reset during data bit 4 abandons the frame silently.
        cycles_per_databit = 10'd13;
        drive(1'b0, 13);
        for (int i = 0; i < 4; i++) drive(i[0], 13);
        drive(1'b0, 6);
        resetn = 1'b0;
        #1;
        chk("midreset_rx_data", rx_data, 0);
        chk("midreset_rx_valid", rx_valid, 0);
        chk("midreset_rx_frame_err", rx_frame_err, 0);
        chk("midreset_rx_busy", rx_busy, 0);
        chk("midreset_curr", curr, 0);
        rx_line = 1'b1;
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        repeat (5) @(negedge clk);
        send_frame(8'h5A, 13, 1'b1, 30);
        check_events("after_reset");
        chk("after_reset_rx_data", rx_data, 8'h5A);

        // Pulse widths and exclusivity over the whole run.
        chk("valid_pulse_cycles", valid_cycles, n_valid_exp);
        chk("err_pulse_cycles", err_cycles, n_err_exp);
        chk("valid_err_exclusive", both_seen, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
